// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame geometry, responder FSM states, status-word layout.
package spi_pkg;

  localparam int unsigned FRAME_BITS_DEF  = 256;
  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned COEF_BITS       = 16;
  localparam int unsigned NUM_COEFS       = 15;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } tx_state_t;

  // Status word (low 16 bits of the readback frame) bit positions.
  localparam int unsigned ST_COEF_VALID_BIT = 0;
  localparam int unsigned ST_RX_ERROR_BIT   = 1;
  localparam int unsigned ST_RX_BUSY_BIT    = 2;
  localparam int unsigned ST_TX_BUSY_BIT    = 3;
  localparam int unsigned ST_FRAME_CNT_LSB  = 8;
  localparam int unsigned ST_FRAME_CNT_W    = 8;

endpackage

// File: rtl/spi_edge_detect.sv
// Synchronizes an asynchronous SPI pin and produces single-cycle rise/fall pulses.
module spi_edge_detect #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic din_i,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  // Synchronizer chain plus one history flop; both reset to RST_VAL so a
  // pin already at RST_VAL across reset release produces no edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {STAGES{RST_VAL}};
      hist_q <= RST_VAL;
    end else begin
      sync_q <= STAGES'({sync_q, din_i});
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign rise_o =  sync_q[STAGES-1] & ~hist_q;
  assign fall_o = ~sync_q[STAGES-1] &  hist_q;

endmodule

// File: rtl/spi_readback_tx.sv
// SPI mode-0 responder that shifts a per-frame snapshot of tx_data out on sdo, MSB first.
module spi_readback_tx
  import spi_pkg::*;
#(
  parameter int unsigned FRAME_BITS  = FRAME_BITS_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  sck,
  input  logic                  cs,
  input  logic [FRAME_BITS-1:0] tx_data,
  output logic                  sdo,
  output logic                  sdo_oe,
  output logic                  tx_busy,
  output logic                  tx_done,
  output logic                  tx_abort,
  output logic [7:0]            frames_sent
);

  localparam int unsigned      CNT_W    = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam int unsigned      SH_W     = FRAME_BITS - 1;

  logic sck_rise, sck_fall, cs_rise, cs_fall;

  spi_edge_detect #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_edge (
    .clk_i  (clk_in),
    .rst_i  (rst_in),
    .din_i  (sck),
    .rise_o (sck_rise),
    .fall_o (sck_fall)
  );

  spi_edge_detect #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_edge (
    .clk_i  (clk_in),
    .rst_i  (rst_in),
    .din_i  (cs),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  // The current bit lives in sdo_q; shreg holds only the bits still to come.
  tx_state_t        state_q, state_d;
  logic [SH_W-1:0]  shreg_q, shreg_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             sdo_q, sdo_d;
  logic             sdo_oe_q, sdo_oe_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             abort_q, abort_d;
  logic [7:0]       frames_q, frames_d;

  // State and output registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      sdo_q     <= 1'b0;
      sdo_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
      frames_q  <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      sdo_q     <= sdo_d;
      sdo_oe_q  <= sdo_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      abort_q   <= abort_d;
      frames_q  <= frames_d;
    end
  end

  // Next-state logic; a cs fall takes priority over any sck edge in the same cycle.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    sdo_d     = sdo_q;
    sdo_oe_d  = sdo_oe_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    abort_d   = 1'b0;
    frames_d  = frames_q;

    case (state_q)
      IDLE: begin
        sdo_d    = 1'b0;
        sdo_oe_d = 1'b0;
        busy_d   = 1'b0;
        if (cs_rise) begin
          shreg_d   = tx_data[SH_W-1:0];
          bit_cnt_d = '0;
          sdo_d     = tx_data[FRAME_BITS-1];
          sdo_oe_d  = 1'b1;
          busy_d    = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (cs_fall) begin
          state_d  = IDLE;
          sdo_d    = 1'b0;
          sdo_oe_d = 1'b0;
          busy_d   = 1'b0;
          if (bit_cnt_q == CNT_FULL) begin
            done_d   = 1'b1;
            frames_d = frames_q + 8'd1;
          end else begin
            abort_d = 1'b1;
          end
        end else if (sck_rise) begin
          if (bit_cnt_q != CNT_FULL) begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end else if (sck_fall && (bit_cnt_q != '0)) begin
          shreg_d = {shreg_q[SH_W-2:0], 1'b0};
          sdo_d   = (bit_cnt_q == CNT_FULL) ? 1'b0 : shreg_q[SH_W-1];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sdo         = sdo_q;
  assign sdo_oe      = sdo_oe_q;
  assign tx_busy     = busy_q;
  assign tx_done     = done_q;
  assign tx_abort    = abort_q;
  assign frames_sent = frames_q;

endmodule

// File: tb/tb_spi_readback_tx.sv
// Randomized bench: an MCU-side driver feeds a 256-bit and an 8-bit responder on a shared bus.
module tb_spi_readback_tx;

  localparam int unsigned FB  = 256;
  localparam int unsigned FBW = 8;

  logic           clk = 1'b0;
  logic           rst, sck, cs;
  logic [FB-1:0]  tx_data;
  logic [FBW-1:0] tx_data_w;
  logic           sdo, sdo_oe, tx_busy, tx_done, tx_abort;
  logic [7:0]     frames_sent;
  logic           sdo_w, sdo_oe_w, tx_busy_w, tx_done_w, tx_abort_w;
  logic [7:0]     frames_sent_w;

  int checks = 0;
  int errors = 0;
  int done_tot = 0, abort_tot = 0, done_w_tot = 0, abort_w_tot = 0;
  logic [7:0] exp_frames, exp_frames_w;

  spi_readback_tx #(.FRAME_BITS(FB), .SYNC_STAGES(2)) u_dut (
    .clk_in(clk), .rst_in(rst), .sck(sck), .cs(cs), .tx_data(tx_data),
    .sdo(sdo), .sdo_oe(sdo_oe), .tx_busy(tx_busy), .tx_done(tx_done),
    .tx_abort(tx_abort), .frames_sent(frames_sent)
  );

  spi_readback_tx #(.FRAME_BITS(FBW), .SYNC_STAGES(2)) u_dut_w (
    .clk_in(clk), .rst_in(rst), .sck(sck), .cs(cs), .tx_data(tx_data_w),
    .sdo(sdo_w), .sdo_oe(sdo_oe_w), .tx_busy(tx_busy_w), .tx_done(tx_done_w),
    .tx_abort(tx_abort_w), .frames_sent(frames_sent_w)
  );

  always #5 clk = ~clk;

  // Counts high cycles of each pulse output, so a frame's delta also proves pulse width.
  always @(negedge clk) begin
    if (tx_done)    done_tot    <= done_tot + 1;
    if (tx_abort)   abort_tot   <= abort_tot + 1;
    if (tx_done_w)  done_w_tot  <= done_w_tot + 1;
    if (tx_abort_w) abort_w_tot <= abort_w_tot + 1;
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) r = {r[223:0], 32'($urandom())};
    return r;
  endfunction

  // One MCU transaction: nbits sck cycles at clk/8, sdo sampled just before each rise.
  // swap_at changes tx_data mid-frame; coincide drops cs together with the last rise.
  task automatic run_frame(input logic [255:0] data, input logic [7:0] data_w, input int nbits,
                           input int swap_at, input logic [255:0] swap_data, input bit coincide);
    logic [255:0] cap, exp_cap;
    logic [7:0]   cap_w, exp_cap_w;
    int ext_ones, d0, a0, dw0, aw0, n_eff;
    bit done_big, done_small;
    cap = '0; cap_w = '0; ext_ones = 0;
    d0 = done_tot; a0 = abort_tot; dw0 = done_w_tot; aw0 = abort_w_tot;
    tx_data = data; tx_data_w = data_w;
    cs = 1'b1;
    tick(6);
    for (int i = 0; i < nbits; i++) begin
      tick(4);
      if (i == swap_at) tx_data = swap_data;
      if (i == 0) begin
        check("oe_in_frame", 256'(sdo_oe), 256'(1));
        check("busy_in_frame", 256'(tx_busy), 256'(1));
      end
      if (i < 256) cap[255-i] = sdo;
      else if (sdo) ext_ones++;
      if (i < 8) cap_w[7-i] = sdo_w;
      sck = 1'b1;
      if (coincide && i == nbits - 1) cs = 1'b0;
      tick(4);
      sck = 1'b0;
    end
    if (!coincide) begin
      tick(4);
      cs = 1'b0;
    end
    tick(4);
    check("oe_after_cs_fall", 256'(sdo_oe), 256'(0));
    check("busy_after_cs_fall", 256'(tx_busy), 256'(0));
    check("oe_w_after_cs_fall", 256'(sdo_oe_w), 256'(0));
    tick(4);

    // Reference: bit i of the MCU capture is snapshot bit (N-1-i) for i<N, else 0;
    // the frame completes only if N rising edges counted before cs fell.
    n_eff = coincide ? nbits - 1 : nbits;
    exp_cap = '0;
    for (int i = 0; i < nbits && i < 256; i++) exp_cap[255-i] = data[255-i];
    exp_cap_w = '0;
    for (int i = 0; i < nbits && i < 8; i++) exp_cap_w[7-i] = data_w[7-i];
    done_big   = (n_eff >= 256);
    done_small = (n_eff >= 8);
    if (done_big)   exp_frames   = exp_frames + 8'd1;
    if (done_small) exp_frames_w = exp_frames_w + 8'd1;

    check("capture", cap, exp_cap);
    check("extra_bits_zero", 256'(ext_ones), 256'(0));
    check("done_pulses", 256'(done_tot - d0), 256'(done_big ? 1 : 0));
    check("abort_pulses", 256'(abort_tot - a0), 256'(done_big ? 0 : 1));
    check("frames_sent", 256'(frames_sent), 256'(exp_frames));
    check("capture_w", 256'(cap_w), 256'(exp_cap_w));
    check("done_w_pulses", 256'(done_w_tot - dw0), 256'(done_small ? 1 : 0));
    check("abort_w_pulses", 256'(abort_w_tot - aw0), 256'(done_small ? 0 : 1));
    check("frames_sent_w", 256'(frames_sent_w), 256'(exp_frames_w));
  endtask

  initial begin
    logic [255:0] pat, d;
    int d0, a0, dw0, aw0;
    rst = 1'b1; sck = 1'b0; cs = 1'b1; tx_data = '0; tx_data_w = '0;
    exp_frames = '0; exp_frames_w = '0;
    tick(4);
    check("rst_sdo", 256'(sdo), 256'(0));
    check("rst_oe", 256'(sdo_oe), 256'(0));
    check("rst_busy", 256'(tx_busy), 256'(0));
    check("rst_done", 256'(tx_done), 256'(0));
    check("rst_abort", 256'(tx_abort), 256'(0));
    check("rst_frames", 256'(frames_sent), 256'(0));
    // cs held high across reset release must not open a frame.
    rst = 1'b0;
    tick(8);
    check("cs_high_at_release_busy", 256'(tx_busy), 256'(0));
    check("cs_high_at_release_oe", 256'(sdo_oe), 256'(0));
    cs = 1'b0;
    tick(6);

    // Full frame with the structured pattern.
    pat = {4{64'h0123456789ABCDEF}};
    d = {16'hA5C3, pat[239:0]};
    run_frame(d, 8'($urandom()), 256, -1, '0, 1'b0);

    // Short frame.
    run_frame(rand256(), 8'($urandom()), 100, -1, '0, 1'b0);

    // Over-clocked frame; trailing bits must read 0 although the payload LSBs are 1.
    run_frame(rand256() | 256'hF, 8'($urandom()), 260, -1, '0, 1'b0);

    // Snapshot isolation, then the new payload on the following frame.
    run_frame('0, 8'h00, 256, 50, {256{1'b1}}, 1'b0);
    run_frame({256{1'b1}}, 8'hFF, 256, -1, '0, 1'b0);

    // Glitch frame: cs pulse with no sck edges.
    run_frame(rand256(), 8'($urandom()), 0, -1, '0, 1'b0);

    // Reset mid-frame at bit 120 with cs held high.
    d0 = done_tot; a0 = abort_tot; dw0 = done_w_tot; aw0 = abort_w_tot;
    tx_data = rand256();
    cs = 1'b1;
    tick(6);
    for (int i = 0; i < 120; i++) begin
      tick(4); sck = 1'b1; tick(4); sck = 1'b0;
    end
    tick(2);
    rst = 1'b1;
    tick(1);
    check("midrst_sdo", 256'(sdo), 256'(0));
    check("midrst_oe", 256'(sdo_oe), 256'(0));
    check("midrst_busy", 256'(tx_busy), 256'(0));
    check("midrst_frames", 256'(frames_sent), 256'(0));
    check("midrst_frames_w", 256'(frames_sent_w), 256'(0));
    tick(1);
    rst = 1'b0;
    exp_frames = '0; exp_frames_w = '0;
    for (int i = 0; i < 30; i++) begin
      tick(4); sck = 1'b1; tick(4); sck = 1'b0;
    end
    tick(2);
    check("postrst_busy", 256'(tx_busy), 256'(0));
    check("postrst_oe", 256'(sdo_oe), 256'(0));
    cs = 1'b0;
    tick(8);
    check("postrst_no_done", 256'(done_tot - d0), 256'(0));
    check("postrst_no_abort", 256'(abort_tot - a0), 256'(0));
    check("postrst_no_done_w", 256'(done_w_tot - dw0), 256'(0));
    check("postrst_no_abort_w", 256'(abort_w_tot - aw0), 256'(0));
    run_frame(rand256(), 8'($urandom()), 256, -1, '0, 1'b0);
    check("frames_after_reset", 256'(frames_sent), 256'(1));

    // 255 more complete frames on the 8-bit responder wrap its counter to 0.
    for (int k = 0; k < 255; k++) begin
      run_frame(rand256(), 8'($urandom()), 8, -1, '0, 1'b0);
    end
    check("frames_w_wrapped", 256'(frames_sent_w), 256'(0));

    // cs fall coincident with the 256th sck rise: edge dropped, frame aborted.
    run_frame(rand256(), 8'($urandom()), 256, -1, '0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_readback_tx.md
Name: spi_readback_tx

Overview:
- SPI responder (FPGA → MCU) for readback of the live filter coefficients and status over the same sck/cs bus the coefficient receiver uses.
- Runs entirely in the clk_in domain. Synchronizes sck and cs, detects their edges, and shifts a snapshot of tx_data out on sdo, MSB first, in SPI mode 0.
- The top level drives tx_data with the packed 15 coefficients (240 bits) plus a 16-bit status word.

Parameters:
- FRAME_BITS, 256: payload bits per frame.
- SYNC_STAGES, 2: synchronizer depth for sck and cs.

Ports:
- clk_in, input, 1: system clock.
- rst_in, input, 1: synchronous, active-high reset.
- sck, input, 1: SPI clock from the MCU, asynchronous to clk_in. f_sck must not exceed f_clk_in/8.
- cs, input, 1: chip select, active-high. A frame lasts while cs=1.
- tx_data, input, FRAME_BITS: payload, sampled once per frame.
- sdo, output, 1: serial data to the MCU.
- sdo_oe, output, 1: sdo output-enable; the pad tristates when 0.
- tx_busy, output, 1: high while a frame is in progress.
- tx_done, output, 1: one-cycle pulse when a frame ends complete.
- tx_abort, output, 1: one-cycle pulse when a frame ends short.
- frames_sent, output, 8: count of complete frames; wraps 255→0.

Behaviour:
- Synchronization
  - sck and cs each pass through a SYNC_STAGES flop chain, then an edge-detect register.
  - The cs history register resets to 1. Therefore cs held high across reset release does not start a frame; a fresh 0→1 transition is required.
- Reset: state=IDLE, sdo=0, sdo_oe=0, tx_busy=0, tx_done=0, tx_abort=0, frames_sent=0, shift register=0, bit_cnt=0.
- IDLE
  - sdo=0, sdo_oe=0.
  - On a synced cs rise: shreg←tx_data, bit_cnt←0, sdo←tx_data[FRAME_BITS-1], sdo_oe←1, tx_busy←1, go to SHIFT.
  - Latency from the cs pin rising to valid sdo is at most SYNC_STAGES+2 clk_in cycles. The MCU must wait at least 4 clk_in cycles after raising cs before the first sck rise.
- SHIFT
  - Synced sck rise (MCU samples): bit_cnt←bit_cnt+1, saturating at FRAME_BITS.
  - Synced sck fall: shreg shifts left with 0 fill; sdo←new MSB. Once FRAME_BITS bits have been sampled, sdo stays 0.
  - A sck fall before the first sck rise of the frame is ignored, so bit 0 is not skipped.
  - Synced cs fall: return to IDLE; sdo=0, sdo_oe=0, tx_busy=0.
    - If bit_cnt==FRAME_BITS: pulse tx_done and increment frames_sent.
    - Otherwise: pulse tx_abort; frames_sent unchanged.
- Simultaneous events: a cs fall and an sck edge in the same cycle → the cs fall wins and the sck edge is dropped.
- Changes to tx_data after the snapshot have no effect until the next frame.
- A cs rise is only recognized in IDLE. Glitch frames (cs high with no sck edges) produce tx_abort.
- rst_in asserted mid-frame: immediate return to IDLE with reset values. No tx_done or tx_abort is pulsed for the killed frame.
- All outputs are registered. bit_cnt width is $clog2(FRAME_BITS+1).

Decomposition:
- Package spi_pkg holds:
  - the FRAME_BITS default (256) and COEF_BITS=16;
  - the tx_state_t enum {IDLE, SHIFT};
  - the status-word bit positions.
- The existing synchronizer module is instantiated for sck and cs.
- A small sub-module, spi_edge_detect (sync chain plus rise/fall pulses), is natural and is shared with future SPI blocks.

Test Plan:
1. Full frame: tx_data = {16'hA5C3, 240'h0123…EF repeated}, cs rise, 256 mode-0 sck cycles at clk_in/8, cs fall → MCU-side capture equals tx_data bit-exactly; tx_done pulses 1 cycle; frames_sent=1; tx_abort never asserts.
2. Short frame: 100 sck cycles, then cs fall → tx_abort one pulse; tx_done=0; frames_sent unchanged; sdo_oe=0 within 4 cycles of the cs fall.
3. Over-clocked frame: 260 sck cycles with tx_data LSB nibble = 4'hF → bits 257–260 read as 0; tx_done pulses; frames_sent increments by 1.
4. Snapshot isolation: change tx_data to all-ones at bit 50 of a frame whose payload is all-zeros → all 256 captured bits are 0; the next frame reads all ones.
5. Reset mid-frame: assert rst_in at bit 120 while holding cs high → all outputs return to reset values; the rest of that frame is ignored; no done/abort pulse. After a cs low→high, a normal frame completes with frames_sent=1.
6. Wrap and simultaneity: 256 complete frames → frames_sent reads 0. A cs fall coincident with the 256th sck rise → tx_abort (edge dropped), not tx_done.
